// File: rtl/calc_sequencer.sv
// calc_sequencer: confirm-driven operand/operator sequencer with a small signed ALU.
// Define CALC_SEQUENCER_DIV_EN to build the iterative restoring divider used for op_sel=11.
module calc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        confirm,
    input  logic        cancel,
    input  logic [1:0]  op_sel,
    input  logic [5:0]  operand1,
    input  logic [5:0]  operand2,
    output logic [2:0]  state,
    output logic [11:0] result,
    output logic        result_valid,
    output logic        error,
    output logic        busy
);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StOp1   = 3'b001,
        StOp1Wr = 3'b010,
        StOp2   = 3'b011,
        StOp2Wr = 3'b100,
        StCalc  = 3'b101,
        StDone  = 3'b110
    } state_t;

    state_t      state_q, state_d;
    logic        confirm_prev_q;
    logic        confirm_edge;
    logic [1:0]  op_q, op_d;
    logic [11:0] result_q, result_d;
    logic        error_q, error_d;
    logic [11:0] a_ext, b_ext;

`ifdef CALC_SEQUENCER_DIV_EN
    logic [2:0] cnt_q;
    logic [5:0] rem_q, rem_d;
    logic [5:0] quo_q, quo_d;
    logic [5:0] dvs_q, dvs_d;
    logic       neg_q, neg_d;
    logic [6:0] rem_shift;

    // Partial remainder shifted left with the next dividend bit from the quotient register.
    assign rem_shift = {rem_q, quo_q[5]};
`endif

    assign confirm_edge = confirm & ~confirm_prev_q;
    assign a_ext        = {{6{operand1[5]}}, operand1};
    assign b_ext        = {{6{operand2[5]}}, operand2};

    assign state        = state_q;
    assign result       = result_q;
    assign error        = error_q;
    assign result_valid = (state_q == StDone);
    assign busy         = (state_q == StCalc);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        error_d  = error_q;
`ifdef CALC_SEQUENCER_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
`endif
        if (cancel) begin
            state_d  = StIdle;
            result_d = '0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle:  if (confirm_edge) state_d = StOp1;
                StOp1:   if (confirm_edge) state_d = StOp1Wr;
                StOp1Wr: state_d = StOp2;
                StOp2:   if (confirm_edge) state_d = StOp2Wr;
                StOp2Wr: begin
                    state_d = StCalc;
                    op_d    = op_sel;
                end
                StCalc: begin
                    case (op_q)
                        2'b00: begin
                            result_d = a_ext + b_ext;
                            error_d  = 1'b0;
                            state_d  = StDone;
                        end
                        2'b01: begin
                            result_d = a_ext - b_ext;
                            error_d  = 1'b0;
                            state_d  = StDone;
                        end
                        2'b10: begin
                            result_d = a_ext * b_ext;
                            error_d  = 1'b0;
                            state_d  = StDone;
                        end
                        default: begin
`ifdef CALC_SEQUENCER_DIV_EN
                            if (cnt_q == 3'd0) begin
                                if (operand2 == 6'd0) begin
                                    result_d = '0;
                                    error_d  = 1'b1;
                                    state_d  = StDone;
                                end else begin
                                    // Magnitudes fit in 6 unsigned bits, including |-32|.
                                    neg_d = operand1[5] ^ operand2[5];
                                    rem_d = '0;
                                    quo_d = operand1[5] ? 6'd0 - operand1 : operand1;
                                    dvs_d = operand2[5] ? 6'd0 - operand2 : operand2;
                                end
                            end else if (cnt_q == 3'd7) begin
                                result_d = neg_q ? 12'd0 - {6'd0, quo_q} : {6'd0, quo_q};
                                error_d  = 1'b0;
                                state_d  = StDone;
                            end else begin
                                quo_d = {quo_q[4:0], 1'b0};
                                if (rem_shift >= {1'b0, dvs_q}) begin
                                    rem_d    = rem_shift[5:0] - dvs_q;
                                    quo_d[0] = 1'b1;
                                end else begin
                                    rem_d = rem_shift[5:0];
                                end
                            end
`else
                            result_d = '0;
                            error_d  = 1'b1;
                            state_d  = StDone;
`endif
                        end
                    endcase
                end
                StDone: begin
                    if (confirm_edge) begin
                        state_d = StOp1;
                        error_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            confirm_prev_q <= 1'b0;
            op_q           <= 2'b00;
            result_q       <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            confirm_prev_q <= confirm;
            op_q           <= op_d;
            result_q       <= result_d;
            error_q        <= error_d;
        end
    end

`ifdef CALC_SEQUENCER_DIV_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            neg_q <= 1'b0;
        end else begin
            // Counts cycles spent in the calculate state; restarts on every entry.
            if (state_q == StCalc && state_d == StCalc) begin
                cnt_q <= cnt_q + 3'd1;
            end else begin
                cnt_q <= '0;
            end
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            neg_q <= neg_d;
        end
    end
`endif

endmodule
